// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access controller.
//   - ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   - PROT_TOP_DEF            : default highest write-protected address
//   - state_t and S_* values  : FSM state encoding (plain 3-bit constants)
package mem_pkg;

    localparam int unsigned ADDR_W_DEF   = 9;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned PROT_TOP_DEF = 'h03F;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_RD_ISSUE = 3'd1;
    localparam state_t S_RD_WAIT  = 3'd2;
    localparam state_t S_RD_CAP   = 3'd3;
    localparam state_t S_WR_ISSUE = 3'd4;
    localparam state_t S_RESP     = 3'd5;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences single read/write accesses from a control unit onto a
// RAM with a one-cycle registered read.
//
// Optional feature: define MEM_WRITE_PROTECT_EN to reject writes whose
// address is <= PROT_TOP (no RAM write, fault pulses together with done).
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   req_rd     in   read request
//   req_wr     in   write request
//   addr       in   request address (MAR)
//   wdata      in   write data (MDR)
//   busy       out  high whenever the FSM is not IDLE
//   done       out  one-cycle completion pulse (RESP state)
//   rdata      out  captured read data, held until the next read capture
//   fault      out  one-cycle request-error pulse
//   ram_read   out  registered RAM read strobe
//   ram_write  out  registered RAM write strobe
//   ram_addr   out  RAM address (latched request address)
//   ram_din    out  RAM write data (latched request data)
//   ram_dout   in   RAM read data, valid the cycle after ram_read
//   state_dbg  out  current FSM state, for observation only
//
// Request handshake: a request is taken on any rising edge where busy=0 and
// exactly one of req_rd/req_wr is high; addr/wdata are latched on that edge.
// Requests while busy=1 are dropped, not queued. Both requests together in
// IDLE are rejected with a fault pulse on the following cycle. Every
// accepted request ends with exactly one done cycle.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned         ADDR_W   = ADDR_W_DEF,
    parameter int unsigned         DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]   PROT_TOP = ADDR_W'(PROT_TOP_DEF)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              fault,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [2:0]        state_dbg
);

    state_t              state_q,     state_d;
    logic                ram_read_q,  ram_read_d;
    logic                ram_write_q, ram_write_d;
    logic                fault_q,     fault_d;
    logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q,   ram_din_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;

    always_comb begin
        state_d     = state_q;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        fault_d     = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_rd && req_wr) begin
                    fault_d = 1'b1;
                end else if (req_rd) begin
                    // Strobe is computed one cycle early so that the
                    // registered ram_read is high exactly during RD_ISSUE.
                    state_d    = S_RD_ISSUE;
                    ram_read_d = 1'b1;
                    ram_addr_d = addr;
                end else if (req_wr) begin
                    ram_addr_d = addr;
                    ram_din_d  = wdata;
`ifdef MEM_WRITE_PROTECT_EN
                    if (addr <= PROT_TOP) begin
                        state_d = S_RESP;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = S_WR_ISSUE;
                        ram_write_d = 1'b1;
                    end
`else
                    state_d     = S_WR_ISSUE;
                    ram_write_d = 1'b1;
`endif
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            // RAM output becomes valid during RD_WAIT; ram_addr is simply held.
            S_RD_WAIT:  state_d = S_RD_CAP;
            S_RD_CAP: begin
                rdata_d = ram_dout;
                state_d = S_RESP;
            end
            S_WR_ISSUE: state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            fault_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            fault_q     <= fault_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rdata_q     <= rdata_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_RESP);
    assign fault     = fault_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rdata     = rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: bench for mem_ctrl with a behavioural RAM (one-cycle
// registered read) and a transaction-level reference model.
module tb_mem_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          clr;
    logic          req_rd;
    logic          req_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          fault;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [2:0]    state_dbg;

    int vecs;
    int errs;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    mem_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .state_dbg (state_dbg)
    );

    // ---------------- RAM with registered read, plus a preload port ----------------
    logic [DW-1:0] ram_mem [DEPTH];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    initial ram_dout = '0;
    always @(posedge clk) begin
        if (pre_we)    ram_mem[pre_addr] <= pre_data;
        if (ram_write) ram_mem[ram_addr] <= ram_din;
        if (ram_read)  ram_dout <= ram_mem[ram_addr];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rdata;

    function automatic bit model_blocked(input logic [AW-1:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return (a <= AW'('h03F));
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        int            lat;
        int            n_rd;
        int            n_wr;
        int            n_both;
        int            n_fault;
        int            n_busy;
        int            n_done;
        logic [DW-1:0] rd_at_done;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_din;
        logic          fault_with_done;
    } obs_t;

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        model_mem[a] = d;
    endtask

    // Issues one request at a negedge and observes 7 following cycles.
    task automatic run_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output obs_t o);
        o = '{lat: -1, n_rd: 0, n_wr: 0, n_both: 0, n_fault: 0, n_busy: 0, n_done: 0,
              rd_at_done: '0, s_addr: '0, s_din: '0, fault_with_done: 1'b0};
        req_rd = rd; req_wr = wr; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        addr = AW'($urandom); wdata = $urandom;
        for (int k = 1; k <= 7; k++) begin
            if (done) begin
                o.n_done++;
                if (o.lat < 0) begin
                    o.lat = k; o.rd_at_done = rdata; o.fault_with_done = fault;
                end
            end
            if (ram_read)  begin o.n_rd++; o.s_addr = ram_addr; end
            if (ram_write) begin o.n_wr++; o.s_addr = ram_addr; o.s_din = ram_din; end
            if (ram_read && ram_write) o.n_both++;
            if (fault) o.n_fault++;
            if (busy)  o.n_busy++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        clr = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        model_rdata = '0;
        // Fill RAM and model with identical random contents while in reset.
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            @(negedge clk);
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = v;
            model_mem[i] = v;
        end
        @(negedge clk);
        pre_we = 1'b0;
        vecs++;
        if ({busy, done, fault, ram_read, ram_write} !== 5'b0 ||
            ram_addr !== '0 || ram_din !== '0 || rdata !== '0) begin
            errs++;
            $display("FAIL reset_outputs busy=%b done=%b fault=%b rd=%b wr=%b addr=%h din=%h rdata=%h want all 0",
                     busy, done, fault, ram_read, ram_write, ram_addr, ram_din, rdata);
        end
        clr = 1'b1;
    endtask

    task automatic test_read_basic;
        obs_t o;
        preload(AW'('h075), 32'h0000_0025);
        run_op(1'b1, 1'b0, AW'('h075), '0, o);
        model_rdata = model_mem['h075];
        vecs++; if (o.lat !== 4) begin errs++; $display("FAIL rd_latency got %0d want 4", o.lat); end
        vecs++; if (o.rd_at_done !== 32'h0000_0025) begin errs++; $display("FAIL rd_data got %h want 00000025", o.rd_at_done); end
        vecs++; if (o.n_busy !== 4) begin errs++; $display("FAIL rd_busy_cycles got %0d want 4", o.n_busy); end
        vecs++; if (o.n_rd !== 1 || o.s_addr !== AW'('h075)) begin errs++; $display("FAIL rd_strobe count=%0d addr=%h want 1 / 075", o.n_rd, o.s_addr); end
        vecs++; if (o.n_wr !== 0 || o.n_done !== 1 || o.n_fault !== 0) begin errs++; $display("FAIL rd_side wr=%0d done=%0d fault=%0d want 0/1/0", o.n_wr, o.n_done, o.n_fault); end
    endtask

    task automatic test_write_read;
        obs_t o;
        run_op(1'b0, 1'b1, AW'('h090), 32'h0000_0067, o);
        model_mem['h090] = 32'h0000_0067;
        vecs++; if (o.lat !== 2) begin errs++; $display("FAIL wr_latency got %0d want 2", o.lat); end
        vecs++; if (o.n_wr !== 1 || o.s_addr !== AW'('h090) || o.s_din !== 32'h0000_0067) begin
            errs++; $display("FAIL wr_strobe count=%0d addr=%h din=%h want 1/090/00000067", o.n_wr, o.s_addr, o.s_din); end
        vecs++; if (o.n_rd !== 0 || o.n_busy !== 2 || o.n_fault !== 0) begin errs++; $display("FAIL wr_side rd=%0d busy=%0d fault=%0d want 0/2/0", o.n_rd, o.n_busy, o.n_fault); end
        vecs++; if (rdata !== model_rdata) begin errs++; $display("FAIL wr_rdata_hold got %h want %h", rdata, model_rdata); end
        run_op(1'b1, 1'b0, AW'('h090), '0, o);
        model_rdata = 32'h0000_0067;
        vecs++; if (o.rd_at_done !== 32'h0000_0067) begin errs++; $display("FAIL wr_readback got %h want 00000067", o.rd_at_done); end
    endtask

    task automatic test_both_req;
        obs_t o;
        run_op(1'b1, 1'b1, AW'('h045), 32'h1234_5678, o);
        vecs++; if (o.n_fault !== 1) begin errs++; $display("FAIL both_fault got %0d pulses want 1", o.n_fault); end
        vecs++; if (o.n_rd !== 0 || o.n_wr !== 0 || o.n_done !== 0 || o.n_busy !== 0) begin
            errs++; $display("FAIL both_quiet rd=%0d wr=%0d done=%0d busy=%0d want 0", o.n_rd, o.n_wr, o.n_done, o.n_busy); end
    endtask

    task automatic test_protect;
        obs_t o;
        logic [DW-1:0] want;
        run_op(1'b0, 1'b1, AW'('h010), 32'hDEAD_BEEF, o);
        if (model_blocked(AW'('h010))) begin
            vecs++; if (o.lat !== 1 || o.fault_with_done !== 1'b1 || o.n_wr !== 0) begin
                errs++; $display("FAIL prot_blocked lat=%0d fault_at_done=%b wr=%0d want 1/1/0", o.lat, o.fault_with_done, o.n_wr); end
        end else begin
            model_mem['h010] = 32'hDEAD_BEEF;
            vecs++; if (o.lat !== 2 || o.n_fault !== 0 || o.n_wr !== 1) begin
                errs++; $display("FAIL prot_open lat=%0d fault=%0d wr=%0d want 2/0/1", o.lat, o.n_fault, o.n_wr); end
        end
        want = model_mem['h010];
        run_op(1'b1, 1'b0, AW'('h010), '0, o);
        model_rdata = want;
        vecs++; if (o.rd_at_done !== want) begin errs++; $display("FAIL prot_readback got %h want %h", o.rd_at_done, want); end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        int n_done;
        preload(AW'('h06A), 32'h0000_0029);
        req_rd = 1'b1; addr = AW'('h050);
        @(posedge clk);
        @(negedge clk);               // RD_ISSUE
        req_rd = 1'b0;
        @(negedge clk);               // RD_WAIT
        clr = 1'b0;
        #1;
        model_rdata = '0;
        vecs++;
        if ({busy, done, fault, ram_read, ram_write} !== 5'b0 ||
            ram_addr !== '0 || ram_din !== '0 || rdata !== '0) begin
            errs++;
            $display("FAIL midreset_outputs busy=%b done=%b fault=%b rd=%b wr=%b addr=%h din=%h rdata=%h want all 0",
                     busy, done, fault, ram_read, ram_write, ram_addr, ram_din, rdata);
        end
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        clr = 1'b1;
        vecs++; if (n_done !== 0) begin errs++; $display("FAIL midreset_done got %0d want 0", n_done); end
        run_op(1'b1, 1'b0, AW'('h06A), '0, o);
        model_rdata = 32'h0000_0029;
        vecs++; if (o.lat !== 4 || o.rd_at_done !== 32'h0000_0029) begin
            errs++; $display("FAIL midreset_read lat=%0d data=%h want 4/00000029", o.lat, o.rd_at_done); end
    endtask

    task automatic test_busy_ignore;
        logic [AW-1:0] a;
        int lat, n_done, n_wr;
        logic [DW-1:0] got;
        a = AW'($urandom_range(DEPTH - 1, 0));
        lat = -1; n_done = 0; n_wr = 0; got = '0;
        req_rd = 1'b1; addr = a;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (done) begin n_done++; if (lat < 0) begin lat = k; got = rdata; end end
            if (ram_write) n_wr++;
            req_wr = (k == 1);
            addr   = AW'($urandom);
            wdata  = $urandom;
            @(negedge clk);
        end
        req_wr = 1'b0;
        model_rdata = model_mem[a];
        vecs++; if (n_done !== 1 || n_wr !== 0 || lat !== 4) begin
            errs++; $display("FAIL busy_ignore done=%0d wr=%0d lat=%0d want 1/0/4", n_done, n_wr, lat); end
        vecs++; if (got !== model_mem[a]) begin errs++; $display("FAIL busy_ignore_data got %h want %h", got, model_mem[a]); end
    endtask

    task automatic test_random;
        obs_t o;
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            kind = $urandom_range(9, 0);
            case ($urandom_range(5, 0))
                0:       a = '0;
                1:       a = '1;
                2:       a = AW'('h03F);
                3:       a = AW'('h040);
                default: a = AW'($urandom);
            endcase
            d = $urandom;
            if (kind == 0) begin
                run_op(1'b1, 1'b1, a, d, o);
                vecs++; if (o.n_fault !== 1 || o.n_done !== 0 || o.n_rd !== 0 || o.n_wr !== 0) begin
                    errs++; $display("FAIL rnd_both addr=%h fault=%0d done=%0d rd=%0d wr=%0d", a, o.n_fault, o.n_done, o.n_rd, o.n_wr); end
            end else if (kind <= 5) begin
                run_op(1'b1, 1'b0, a, d, o);
                model_rdata = model_mem[a];
                vecs++; if (o.lat !== 4 || o.rd_at_done !== model_rdata || o.n_rd !== 1 || o.s_addr !== a) begin
                    errs++; $display("FAIL rnd_read addr=%h lat=%0d got %h want %h rd=%0d raddr=%h",
                                     a, o.lat, o.rd_at_done, model_rdata, o.n_rd, o.s_addr); end
            end else if (model_blocked(a)) begin
                run_op(1'b0, 1'b1, a, d, o);
                vecs++; if (o.lat !== 1 || o.fault_with_done !== 1'b1 || o.n_wr !== 0) begin
                    errs++; $display("FAIL rnd_wr_blocked addr=%h lat=%0d fault=%b wr=%0d want 1/1/0", a, o.lat, o.fault_with_done, o.n_wr); end
            end else begin
                run_op(1'b0, 1'b1, a, d, o);
                model_mem[a] = d;
                vecs++; if (o.lat !== 2 || o.n_wr !== 1 || o.s_addr !== a || o.s_din !== d || o.n_fault !== 0) begin
                    errs++; $display("FAIL rnd_write addr=%h lat=%0d wr=%0d waddr=%h din=%h want %h fault=%0d",
                                     a, o.lat, o.n_wr, o.s_addr, o.s_din, d, o.n_fault); end
            end
            vecs++; if (o.n_both !== 0 || rdata !== model_rdata) begin
                errs++; $display("FAIL rnd_hold both_strobes=%0d rdata=%h want 0/%h", o.n_both, rdata, model_rdata); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_read_basic();
        test_write_read();
        test_both_req();
        test_protect();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter PROT_TOP, default 9'h03F, SHALL be the highest write-protected address.
REQ-004 clk  in  1: SHALL be the single clock, rising edge.
REQ-005 clr  in  1: SHALL be the asynchronous, active-low reset.
REQ-006 req_rd  in  1: SHALL be the read request from the control unit.
REQ-007 req_wr  in  1: SHALL be the write request from the control unit.
REQ-008 addr  in  ADDR_W: SHALL be the request address (MAR contents).
REQ-009 wdata  in  DATA_W: SHALL be the write data (MDR contents).
REQ-010 busy  out  1: SHALL be high whenever the FSM is not IDLE.
REQ-011 done  out  1: SHALL be a one-cycle completion pulse.
REQ-012 rdata  out  DATA_W: SHALL be the captured read data for the MDR.
REQ-013 fault  out  1: SHALL be a one-cycle request-error pulse.
REQ-014 ram_read, ram_write  out  1 each: SHALL be the RAM strobes.
REQ-015 ram_addr  out  ADDR_W, ram_din  out  DATA_W, ram_dout  in  DATA_W: SHALL form the RAM data path.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ISSUE, RD_WAIT, RD_CAP, WR_ISSUE and RESP.
REQ-017 In IDLE, a request SHALL be accepted on the rising edge, latching addr and wdata into internal registers.
REQ-018 Requests arriving while busy=1 SHALL be ignored, with no queueing.
REQ-019 req_rd=1 and req_wr=1 together in IDLE SHALL cause no RAM access, pulse fault the next cycle, and keep the FSM in IDLE.
REQ-020 Read sequence: IDLE->RD_ISSUE->RD_WAIT->RD_CAP->RESP->IDLE.
REQ-021 In RD_ISSUE, ram_read=1 and ram_addr=latched address.
REQ-022 In RD_WAIT, ram_addr SHALL be held to cover the RAM's one-cycle registered-read latency.
REQ-023 At the end of RD_CAP, ram_dout SHALL be registered into rdata.
REQ-024 Write sequence: IDLE->WR_ISSUE->RESP->IDLE; in WR_ISSUE, ram_write=1, ram_addr=latched address, ram_din=latched data.
REQ-025 done=1 SHALL be asserted in RESP only, and SHALL be exactly one cycle wide.
REQ-026 Read latency SHALL be 4 cycles from the accept edge to done; write latency SHALL be 2 cycles.
REQ-027 rdata SHALL hold its value until the next read capture; writes SHALL NOT alter it.
REQ-028 ram_read and ram_write SHALL never both be 1, and each SHALL be registered (glitch-free).
REQ-029 Addresses SHALL be used unmodified, with no wrap or offset; the full 0..2^ADDR_W-1 range is valid.

Reset
REQ-030 clr=0 SHALL asynchronously force: state=IDLE; busy=0, done=0, fault=0, ram_read=0, ram_write=0; ram_addr=0, ram_din=0, rdata=0.
REQ-031 On reset mid-operation, the in-flight access SHALL be abandoned without a done pulse; a write not yet sampled by RAM is lost.
REQ-032 The first request SHALL be accepted on the first rising edge after clr deasserts.

Configuration
REQ-033 With MEM_WRITE_PROTECT_EN defined, a write with latched address <= PROT_TOP SHALL skip WR_ISSUE, keep ram_write=0, go to RESP, and pulse fault together with done.
REQ-034 Without MEM_WRITE_PROTECT_EN, all writes SHALL proceed, and fault SHALL come only from simultaneous requests.

Structure
REQ-035 A shared package mem_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and PROT_TOP.
REQ-036 The design SHALL use a single module with no sub-modules; the RAM is instantiated alongside it, not inside it.

Verification
REQ-037 Preload RAM[0x075]=0x00000025; req_rd, addr=0x075 -> done 4 cycles later, rdata=0x00000025, busy high for cycles 1-4.
REQ-038 req_wr, addr=0x090, wdata=0x00000067, then read 0x090 -> ram_write pulse 1 cycle, done after 2 cycles, read returns 0x00000067.
REQ-039 req_rd=req_wr=1, addr=0x045 -> fault pulse, no ram_read/ram_write, done stays 0, busy stays 0.
REQ-040 Write 0x010 with data 0xDEADBEEF and MEM_WRITE_PROTECT_EN -> fault+done, RAM[0x010] unchanged; without the macro -> RAM[0x010]=0xDEADBEEF.
REQ-041 Assert clr=0 during RD_WAIT -> all outputs 0 immediately, no done; a read of 0x06A after release returns RAM[0x06A]=0x00000029.
REQ-042 Pulse req_wr while busy=1 during a read -> write ignored, only the read's done appears.
